iob_skid_buf: RTL
=================

# iob_skid_buf

Registered valid/ready pipeline stage with a one-entry skid register. It cuts every combinational path between producer and consumer: data, valid and ready are all register outputs. It sits directly upstream of enabled-register stages such as `iob_reg_e`, where it generates the transfer pulse that drives their `en_i` and delivers the data word they capture. Full throughput is one word per cycle with one cycle of latency.

## Interface
- `DATA_W`, 32, payload width in bits.
- `RST_VAL`, `{DATA_W{1'b0}}`, value of `data_o` and of both storage registers after reset.
- `CNT_W`, 16, width of the stall counter.

- `clk_i`  in  1  single clock; all logic is rising-edge.
- `cke_i`  in  1  clock enable; when low, all state holds.
- `rst_i`  in  1  reset, synchronous and active-high; the block has one clock, and its reset is synchronous and active-high.
- `valid_i`  in  1  upstream word valid.
- `data_i`  in  DATA_W  upstream word.
- `ready_o`  out  1  block can accept a word.
- `valid_o`  out  1  `data_o` holds a valid word.
- `data_o`  out  DATA_W  head word.
- `ready_i`  in  1  downstream accepts `data_o`.
- `xfer_o`  out  1  `valid_o & ready_i & cke_i`; this pulse drives the downstream `en_i`.
- `stall_cnt_o`  out  CNT_W  saturating count of stalled cycles.

## Operation
- An input transfer (IN) is `valid_i & ready_o & cke_i`.
- An output transfer (OUT) is `valid_o & ready_i & cke_i`.
- Storage consists of a main register (drives `data_o`) and a skid register. Each register has a synchronous reset and a load enable.
- The FSM has three states: EMPTY, BUSY (main full) and FULL (main and skid full).
- EMPTY:
  - IN: main ← `data_i`, next state BUSY.
  - Otherwise: stay in EMPTY.
- BUSY:
  - IN & OUT: main ← `data_i`, stay in BUSY.
  - IN & !OUT: skid ← `data_i`, next state FULL.
  - !IN & OUT: next state EMPTY. Main holds its old value.
  - Neither: stay in BUSY.
- FULL:
  - OUT: main ← skid, next state BUSY.
  - Otherwise: stay in FULL. IN cannot occur in this state.
- `valid_o` = (state != EMPTY).
- `ready_o` = (state != FULL). It is decoded from state registers only and never depends on `ready_i` or `valid_i`.
- Word order is strictly preserved. No word is dropped or duplicated.
- `data_o` is don't-care when `valid_o` = 0. It is still held stable, with no spurious loads.
- Stall counter:
  - Increments by 1 on each cycle with `valid_o & !ready_i & cke_i`.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Cleared only by reset.

## Timing
- Reset takes effect on the first rising edge with `rst_i`=1, independent of `cke_i`. Values on the cycle after:
  - state EMPTY
  - `valid_o`=0
  - `ready_o`=1
  - `data_o`=RST_VAL
  - skid=RST_VAL
  - `xfer_o`=0
  - `stall_cnt_o`=0
- Reset asserted mid-operation discards both held words. No transfer completes on that edge.
- Latency: a word accepted at edge N appears on `data_o` with `valid_o`=1 after edge N.
- Throughput: with `ready_i` held at 1, the block accepts one word per cycle indefinitely and never enters FULL.
- `ready_o` falls one cycle after the downstream stalls. The word accepted during that cycle goes to skid.
- `ready_o` rises the cycle after the OUT that leaves FULL.
- When `cke_i`=0, no transfer occurs, all registers hold, and `xfer_o`=0.
- `xfer_o` is combinational from `valid_o`, `ready_i` and `cke_i`. It is the only output with an input-to-output path.

## Configuration
- Macro: `IOB_SKID_BUF_STALL_CNT_EN`.
- Defined: the stall counter is built as described in Operation.
- Undefined: no counter flops are built and `stall_cnt_o` is tied to 0. The port list is unchanged.

## Structure
- The shared package `iob_skid_buf_pkg` holds:
  - the state encoding typedef: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2
  - the default values of `DATA_W` and `CNT_W`
- Sub-module `iob_reg_re`: register with synchronous reset, clock enable and load enable. It is instantiated twice, once for main and once for skid.

## Test plan
- Reset, then idle: `valid_o`=0, `ready_o`=1, `data_o`=RST_VAL, `stall_cnt_o`=0.
- Stream 0x1..0x8 with `ready_i`=1:
  - outputs 0x1..0x8 on consecutive cycles, each one cycle after its input
  - `ready_o` stays 1
  - `xfer_o` asserts for 8 cycles
- Stall and release:
  - Send 0xA and 0xB back-to-back while `ready_i`=0: state FULL, `ready_o`=0, `data_o`=0xA.
  - Raise `ready_i`: 0xA then 0xB appear, then `ready_o`=1.
  - `stall_cnt_o` has counted the stalled cycles exactly.
- Random `valid_i`/`ready_i` over 10,000 cycles: the output sequence equals the input sequence, and `ready_o` never toggles in response to `ready_i` within the same cycle.
- Hold `cke_i`=0 for 5 cycles in FULL with `ready_i`=1: no transfer, registers unchanged, and `xfer_o`=0.
- Assert `rst_i` in FULL:
  - next cycle `valid_o`=0, `ready_o`=1, `data_o`=RST_VAL
  - With the macro defined and CNT_W=2, 5 stalled cycles leave `stall_cnt_o`=3.

Source files
------------

// File: rtl/iob_skid_buf_pkg.sv
// Shared definitions for iob_skid_buf: state encoding and default widths.
package iob_skid_buf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    // EMPTY: nothing held, BUSY: main full, FULL: main and skid full
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/iob_reg_re.sv
// Register with synchronous reset, clock enable and load enable.
// Reset wins over the clock enable so the register clears even while stalled.
module iob_reg_re #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Storage flop: reset first, then load only when both enables are high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i && en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_skid_buf.sv
// Registered valid/ready stage with a one-entry skid register.
// data_o, valid_o and ready_o come from flops; xfer_o is the only
// combinational output and feeds the downstream register enable.
// Optional stall counter: define IOB_SKID_BUF_STALL_CNT_EN to build it,
// otherwise stall_cnt_o is tied to zero.
module iob_skid_buf
    import iob_skid_buf_pkg::*;
#(
    parameter int unsigned       DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W   = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic              xfer_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_t            state;
    state_t            state_nxt;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_en;
    logic              skid_en;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    // Handshake decode: valid/ready depend on the state flops only
    assign valid_o  = (state != EMPTY);
    assign ready_o  = (state != FULL);
    assign in_xfer  = valid_i & ready_o & cke_i;
    assign out_xfer = valid_o & ready_i & cke_i;
    assign xfer_o   = out_xfer;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    // Next state and register load controls
    always_comb begin
        state_nxt      = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_en   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en   = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : data_i;

    // Head word register, drives data_o directly
    iob_reg_re #(
        .DATA_W (DATA_W),
        .RST_VAL(RST_VAL)
    ) u_main (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (main_en),
        .data_i(main_d),
        .data_o(data_o)
    );

    // Skid register, catches the word accepted while downstream stalls
    iob_reg_re #(
        .DATA_W (DATA_W),
        .RST_VAL(RST_VAL)
    ) u_skid (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .rst_i (rst_i),
        .en_i  (skid_en),
        .data_i(data_i),
        .data_o(skid_q)
    );

`ifdef IOB_SKID_BUF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles where a valid head word is refused
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (cke_i && valid_o && !ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
